// File: rtl/eprom_pkg.sv
// Shared types and default geometry for the EPROM programming controller.
package eprom_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 16;
   localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

   typedef enum logic [2:0] {
      IDLE,
      ERASE,
      PROG,
      VERIFY,
      FIN
   } state_t;

endpackage

// File: rtl/eprom_sum_acc.sv
// DATA_W wrapping accumulator; clr has priority over add_en.
module eprom_sum_acc #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              add_en,
   input  logic [DATA_W-1:0] add_val,
   output logic [DATA_W-1:0] sum
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sum + add_val;
      end
   end

endmodule

// File: rtl/eprom_programmer.sv
// EPROM programming controller: erase, program DEPTH words, optional read-back verify.
// Read-back checksum verify is built only when EPROM_PROG_VERIFY_EN is defined.
module eprom_programmer
   import eprom_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [DATA_W-1:0] checksum,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_erase,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic             job_start;
   logic             accept;
   logic             last_word;

   assign job_start = (state == IDLE) && start;
   assign accept    = (state == PROG) && in_valid;
   assign last_word = accept && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (start) next_state = ERASE;
         ERASE:  next_state = PROG;
`ifdef EPROM_PROG_VERIFY_EN
         PROG:   if (last_word) next_state = VERIFY;
`else
         PROG:   if (last_word) next_state = FIN;
`endif
         VERIFY: if (cnt == LAST) next_state = FIN;
         FIN:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Address/handshake outputs are combinational so a word is written the cycle it is offered.
   always_comb begin
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_erase = 1'b0;
      mem_addr  = '0;
      busy      = (state != IDLE);
      done      = (state == FIN);
      case (state)
         ERASE: mem_erase = 1'b1;
         PROG: begin
            in_ready  = 1'b1;
            mem_we    = in_valid;
            mem_wdata = in_data;
            mem_addr  = cnt[ADDR_W-1:0];
         end
         VERIFY: mem_addr = cnt[ADDR_W-1:0];
         default: ;
      endcase
   end

   // cnt is one bit wider than the address so the full DEPTH range is representable.
   always_ff @(posedge clk) begin
      if (rst || job_start) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= last_word ? '0 : cnt + CNT_W'(1);
      end else if (state == VERIFY) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

   eprom_sum_acc #(.DATA_W(DATA_W)) u_checksum (
      .clk     (clk),
      .rst     (rst),
      .clr     (job_start),
      .add_en  (accept),
      .add_val (in_data),
      .sum     (checksum)
   );

`ifdef EPROM_PROG_VERIFY_EN
   logic [DATA_W-1:0] vsum;
   logic [DATA_W-1:0] final_sum;

   eprom_sum_acc #(.DATA_W(DATA_W)) u_vsum (
      .clk     (clk),
      .rst     (rst),
      .clr     (job_start),
      .add_en  (state == VERIFY),
      .add_val (mem_rdata),
      .sum     (vsum)
   );

   // The last read word is folded in combinationally so the flag is ready in FIN.
   assign final_sum = vsum + mem_rdata;

   always_ff @(posedge clk) begin
      if (rst || job_start) begin
         verify_err <= 1'b0;
      end else if ((state == VERIFY) && (cnt == LAST) && (final_sum != checksum)) begin
         verify_err <= 1'b1;
      end
   end
`else
   logic unused_rdata;

   assign unused_rdata = ^mem_rdata;
   assign verify_err   = 1'b0;
`endif

endmodule

// File: tb/tb_eprom_programmer.sv
// Directed self-checking bench for eprom_programmer with a behavioural EPROM model.
module tb_eprom_programmer;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
`ifdef EPROM_PROG_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              busy;
   logic              done;
   logic              verify_err;
   logic [DATA_W-1:0] checksum;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_erase;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] stuck_mask;

   int n_checks = 0;
   int n_pass   = 0;

   int done_cyc;
   int n_wr;
   bit addr_ok, we_ok, excl_ok, erase_ok;

   eprom_programmer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .busy       (busy),
      .done       (done),
      .verify_err (verify_err),
      .checksum   (checksum),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_erase  (mem_erase),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // EPROM model: erase clears the array, address 5 can have stuck-at-0 bits.
   always @(posedge clk) begin
      if (mem_erase) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[mem_addr] <= (mem_addr == 4'd5) ? (mem_wdata & ~stuck_mask) : mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [DATA_W-1:0] word(input int kind, input int i);
      case (kind)
         0:       return 16'h1000 + 16'(i);
         1:       return 16'hFFFF;
         default: return (i == 5) ? 16'h0001 : 16'h0000;
      endcase
   endfunction

   // Cycle 0 samples start; mode 0 = valid every cycle, mode 1 = valid on odd cycles.
   task automatic run_job(input int kind, input int mode, input int hold,
                          input int pulse, input int rst_after);
      int idx;
      idx      = 0;
      done_cyc = -1;
      n_wr     = 0;
      addr_ok  = 1'b1;
      we_ok    = 1'b1;
      excl_ok  = 1'b1;
      erase_ok = 1'b1;
      @(negedge clk);
      start    = 1'b1;
      in_valid = 1'b0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         start    = (c < hold) || (c == pulse);
         in_valid = (mode == 0) ? 1'b1 : ((c % 2) == 1);
         in_data  = word(kind, idx);
         if (rst_after >= 0 && idx == rst_after) rst = 1'b1;
         #1;
         if (c == 1) erase_ok = mem_erase && !mem_we && busy;
         else if (mem_erase) erase_ok = 1'b0;
         if (mem_erase && mem_we) excl_ok = 1'b0;
         if (rst) break;
         if (mem_we !== (in_ready && in_valid)) we_ok = 1'b0;
         if (mem_we) begin
            n_wr++;
            if (mem_addr !== 4'(idx) || mem_wdata !== in_data) addr_ok = 1'b0;
         end
         if (in_ready && in_valid) idx++;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      bit quiet;
      rst        = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b1;
      in_data    = 16'hABCD;
      stuck_mask = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready",   in_ready,   0);
      check("rst_busy",       busy,       0);
      check("rst_done",       done,       0);
      check("rst_verify_err", verify_err, 0);
      check("rst_checksum",   checksum,   0);
      check("rst_mem_addr",   mem_addr,   0);
      check("rst_mem_we",     mem_we,     0);
      check("rst_mem_wdata",  mem_wdata,  0);
      check("rst_mem_erase",  mem_erase,  0);
      rst      = 1'b0;
      in_valid = 1'b0;

      // Continuous 0x1000+i
      run_job(0, 0, 1, -1, -1);
      check("t1_erase",    erase_ok, 1);
      check("t1_excl",     excl_ok,  1);
      check("t1_writes",   n_wr,     16);
      check("t1_addr",     addr_ok,  1);
      check("t1_we",       we_ok,    1);
      check("t1_done_cyc", done_cyc, VER ? 34 : 18);
      check("t1_checksum", checksum, 16'h0078);
      check("t1_verr",     verify_err, 0);
      @(negedge clk); #1;
      check("t1_idle_busy", busy, 0);
      check("t1_mem15",     mem[15], 16'h100F);

      // Valid every other cycle
      run_job(0, 1, 1, -1, -1);
      check("t2_done_cyc", done_cyc, VER ? 50 : 34);
      check("t2_writes",   n_wr,     16);
      check("t2_we",       we_ok,    1);
      check("t2_addr",     addr_ok,  1);
      check("t2_checksum", checksum, 16'h0078);

      // Stuck-at-0 bit 0 at address 5
      stuck_mask = 16'h0001;
      run_job(2, 0, 1, -1, -1);
      check("t3_done_cyc", done_cyc, VER ? 34 : 18);
      check("t3_checksum", checksum, 16'h0001);
      check("t3_verr",     verify_err, 32'(VER));
      repeat (3) @(negedge clk);
      #1;
      check("t3_verr_sticky", verify_err, 32'(VER));
      stuck_mask = '0;

      // start pulse mid-PROG is ignored; verify_err cleared by the new start
      run_job(0, 0, 1, 6, -1);
      check("t4_done_cyc", done_cyc, VER ? 34 : 18);
      check("t4_writes",   n_wr,     16);
      check("t4_verr_clr", verify_err, 0);

      // start held 3 cycles, 0xFFFF words wrap the checksum
      run_job(1, 0, 3, -1, -1);
      check("t5_done_cyc", done_cyc, VER ? 34 : 18);
      check("t5_checksum", checksum, 16'hFFF0);
      check("t5_verr",     verify_err, 0);
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (busy) quiet = 1'b0;
      end
      check("t5_one_job", quiet, 1);

      // Reset after 7 accepted words
      run_job(0, 0, 1, -1, 7);
      check("t6_writes_before_rst", n_wr, 7);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      #1;
      check("t6_ctl_zero",  {in_ready, busy, done, verify_err, mem_we, mem_erase}, 0);
      check("t6_checksum",  checksum,  0);
      check("t6_mem_addr",  mem_addr,  0);
      check("t6_mem_wdata", mem_wdata, 0);
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (mem_we) quiet = 1'b0;
      end
      check("t6_no_we", quiet, 1);
      in_valid = 1'b0;
      run_job(0, 0, 1, -1, -1);
      check("t6_reerase",   erase_ok, 1);
      check("t6_addr",      addr_ok,  1);
      check("t6_writes",    n_wr,     16);
      check("t6_done_cyc",  done_cyc, VER ? 34 : 18);
      check("t6_checksum2", checksum, 16'h0078);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
